// File: rtl/cla_seq_adder.sv
// Sequential wide adder: feeds one nibble per clock through a 4-bit carry-lookahead slice.
// Optional signed-overflow output is enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    input  logic                 cin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] sum_o,
`ifdef CLA_SEQ_OVF_EN
    output logic                 ovf_o,
`endif
    output logic                 cout_o
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    // 4-bit carry-lookahead slice on the current low nibble
    logic [3:0] sl_p, sl_g, sl_c, sl_s;
    logic       sl_cout;
    logic [W-1:0] acc_shift;

    always_comb begin
        sl_p    = op_a_q[3:0] ^ op_b_q[3:0];
        sl_g    = op_a_q[3:0] & op_b_q[3:0];
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0] | (sl_p[0] & carry_q);
        sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry_q);
        sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
        sl_cout = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
        sl_s    = sl_p ^ sl_c;
    end

    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom
    assign acc_shift = W'({sl_s, acc_q} >> 4);

`ifdef CLA_SEQ_OVF_EN
    logic msb_a_q, msb_a_d;
    logic msb_b_q, msb_b_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
        msb_a_d = msb_a_q;
        msb_b_d = msb_b_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_a_d  = a_i;
                    op_b_d  = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = StRun;
`ifdef CLA_SEQ_OVF_EN
                    msb_a_d = a_i[W-1];
                    msb_b_d = b_i[W-1];
`endif
                end
            end
            StRun: begin
                acc_d   = acc_shift;
                op_a_d  = op_a_q >> 4;
                op_b_d  = op_b_q >> 4;
                carry_d = sl_cout;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == IdxLast) begin
                    sum_d   = acc_shift;
                    cout_d  = sl_cout;
                    state_d = StDone;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = (msb_a_q == msb_b_q) && (acc_shift[W-1] != msb_a_q);
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

`ifdef CLA_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed cases plus random adds against an
// arithmetic reference, on a 4-nibble and a 1-nibble instance.
module tb_cla_seq_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk;
    logic rst_n;

    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         ovf;

    logic       start1;
    logic [3:0] a1, b1;
    logic       cin1;
    logic       busy1, done1, cout1;
    logic [3:0] sum1;
    logic       ovf1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] prev_res;
    logic       prev_ovf;
    logic [4:0] prev_res1;

    cla_seq_adder #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
`ifdef CLA_SEQ_OVF_EN
        .ovf_o   (ovf),
`endif
        .cout_o  (cout)
    );

    cla_seq_adder #(.NIBBLES(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start1),
        .a_i     (a1),
        .b_i     (b1),
        .cin_i   (cin1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
`ifdef CLA_SEQ_OVF_EN
        .ovf_o   (ovf1),
`endif
        .cout_o  (cout1)
    );

`ifndef CLA_SEQ_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on the wide instance; optionally keeps start high with junk operands
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit hammer);
        logic [W:0] exp;
        logic       exp_ovf;
        int         cyc;
        exp     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_ovf = (a[W-1] == b[W-1]) && (exp[W-1] != a[W-1]);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin = c;
        @(posedge clk); #1;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = hammer;
        a_in  = hammer ? 16'hAAAA : W'($urandom);
        b_in  = hammer ? 16'h5555 : W'($urandom);
        cin   = hammer ? 1'b0 : 1'($urandom);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            check("result_hold", {47'd0, cout, sum}, {47'd0, prev_res});
        end
        check("latency", 64'(cyc), 64'(N));
        check("sum", {48'd0, sum}, {48'd0, exp[W-1:0]});
        check("cout", {63'd0, cout}, {63'd0, exp[W]});
`ifdef CLA_SEQ_OVF_EN
        check("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
        prev_ovf = exp_ovf;
`endif
        prev_res = exp;
        @(posedge clk); #1;
        check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    endtask

    task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] exp;
        int         cyc;
        exp = {1'b0, a} + {1'b0, b} + {4'd0, c};
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        @(posedge clk); #1;
        @(negedge clk);
        start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
        cyc = 0;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (done1) break;
        end
        check("n1_latency", 64'(cyc), 64'd1);
        check("n1_result", {59'd0, cout1, sum1}, {59'd0, exp});
        prev_res1 = exp;
        @(posedge clk); #1;
        check("n1_done_one_cycle", {63'd0, done1}, 64'd0);
    endtask

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        prev_res = '0; prev_res1 = '0; prev_ovf = 1'b0;
        #12;
        check("reset_outputs", {44'd0, ovf, busy, done, cout, sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {62'd0, busy, done}, 64'd0);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op1(4'hD, 4'hB, 1'b0);
        run_op1(4'hF, 4'hF, 1'b1);

        // start held high through RUN and DONE must not disturb the in-flight add
        run_op(16'h0001, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("hammer_accepted", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        check("hammer_done", {63'd0, done}, 64'd1);
        check("hammer_sum", {47'd0, cout, sum}, 64'h0FFFF);
        prev_res = 17'h0FFFF;
        @(posedge clk); #1;

        // reset mid-RUN abandons the operation
        @(negedge clk);
        start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {44'd0, ovf, busy, done, cout, sum}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_res = '0; prev_res1 = '0; prev_ovf = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("no_done_after_reset", {63'd0, seen_done}, 64'd0);
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            run_op1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
